// File: rtl/ibuffer_pkg.sv
// Shared constants and slot payload type for the instruction buffer.
package ibuffer_pkg;

  localparam int unsigned IBUF_SLOTS      = 16;
  localparam int unsigned IBUF_BANK_SLOTS = 8;
  localparam int unsigned IBUF_WAYS       = 4;
  localparam int unsigned IBUF_HW_W       = 16;
  localparam int unsigned IBUF_INSTR_W    = 2 * IBUF_HW_W;
  localparam int unsigned IBUF_IDX_W      = $clog2(IBUF_SLOTS);
  localparam int unsigned IBUF_BLK_OFS_W  = 4;

  typedef struct packed {
    logic                 valid;
    logic                 uncompressed;
    logic                 redirect;
    logic [IBUF_HW_W-1:0] hw;
  } ibuf_slot_t;

  function automatic ibuf_slot_t ibuf_mk_slot(input logic                 valid,
                                              input logic                 uncompressed,
                                              input logic                 redirect,
                                              input logic [IBUF_HW_W-1:0] hw);
    ibuf_slot_t slot;
    slot.valid        = valid;
    slot.uncompressed = uncompressed;
    slot.redirect     = redirect;
    slot.hw           = hw;
    return slot;
  endfunction

endpackage

// File: rtl/ibuffer_ctrl_if.sv
// Fetch-side enqueue and decode-side dequeue bundle of the instruction buffer.
interface ibuffer_ctrl_if #(
  parameter int unsigned PC_WIDTH = 32
) ();
  import ibuffer_pkg::*;

  logic                                             flush;
  logic                                             enq_valid;
  logic                                             enq_ready;
  logic [IBUF_BANK_SLOTS-1:0]                       enq_valid_vec;
  logic [IBUF_BANK_SLOTS-1:0]                       enq_uncompressed_vec;
  logic [IBUF_BANK_SLOTS-1:0]                       enq_redirect_vec;
  logic [IBUF_BANK_SLOTS-1:0][IBUF_HW_W-1:0]        enq_halfword_by_slot;
  logic [PC_WIDTH-1:0]                              enq_pc;
  logic [IBUF_WAYS-1:0]                             deq_valid_by_way;
  logic                                             deq_ready;
  logic [IBUF_WAYS-1:0][IBUF_INSTR_W-1:0]           deq_instr_by_way;
  logic [IBUF_WAYS-1:0][PC_WIDTH-1:0]               deq_pc_by_way;
  logic [IBUF_WAYS-1:0]                             deq_uncompressed_by_way;
  logic [IBUF_WAYS-1:0]                             deq_redirect_by_way;

  modport master (
    output flush, enq_valid, enq_valid_vec, enq_uncompressed_vec, enq_redirect_vec,
           enq_halfword_by_slot, enq_pc, deq_ready,
    input  enq_ready, deq_valid_by_way, deq_instr_by_way, deq_pc_by_way,
           deq_uncompressed_by_way, deq_redirect_by_way
  );

  modport slave (
    input  flush, enq_valid, enq_valid_vec, enq_uncompressed_vec, enq_redirect_vec,
           enq_halfword_by_slot, enq_pc, deq_ready,
    output enq_ready, deq_valid_by_way, deq_instr_by_way, deq_pc_by_way,
           deq_uncompressed_by_way, deq_redirect_by_way
  );

endinterface

// File: rtl/ibuffer_deqer.sv
// Picks up to four in-order instructions from the 16 slot flags, starting at the
// lowest valid slot, and reports which slots they consume.
module ibuffer_deqer
  import ibuffer_pkg::*;
(
  input  logic [IBUF_SLOTS-1:0]                  i_valid_vec,
  input  logic [IBUF_SLOTS-1:0]                  i_uncompressed_vec,
  input  logic [IBUF_SLOTS-1:0]                  i_redirect_vec,
  output logic [IBUF_WAYS-1:0]                   o_valid_by_way_c,
  output logic [IBUF_WAYS-1:0][IBUF_IDX_W-1:0]   o_first_idx_by_way_c,
  output logic [IBUF_SLOTS-1:0]                  o_deqing_vec_c
);

  localparam int unsigned PTR_W = IBUF_IDX_W + 1;
  localparam logic [IBUF_IDX_W-1:0] LAST_IDX = IBUF_IDX_W'(IBUF_SLOTS - 1);

  logic [PTR_W-1:0]      w_ptr;
  logic [IBUF_IDX_W-1:0] w_cur;
  logic [IBUF_IDX_W-1:0] w_nxt;
  logic                  w_stop;
  logic                  w_unused_redirect;

  // Only the last slot's redirect bit affects sequencing; the rest ride along as payload.
  assign w_unused_redirect = ^i_redirect_vec[IBUF_SLOTS-2:0];

  // Sequential scan: a 32b instruction needs its upper halfword present, except a
  // redirecting one in the last slot; the first blocked way stops all younger ways.
  always_comb begin
    w_ptr                = PTR_W'(IBUF_SLOTS);
    w_cur                = '0;
    w_nxt                = '0;
    w_stop               = 1'b0;
    o_valid_by_way_c     = '0;
    o_first_idx_by_way_c = '0;
    o_deqing_vec_c       = '0;

    for (int i = IBUF_SLOTS - 1; i >= 0; i--) begin
      if (i_valid_vec[i]) w_ptr = PTR_W'(i);
    end

    for (int k = 0; k < IBUF_WAYS; k++) begin
      w_cur                   = w_ptr[IBUF_IDX_W-1:0];
      w_nxt                   = w_cur + IBUF_IDX_W'(1);
      o_first_idx_by_way_c[k] = w_cur;
      if (w_stop || w_ptr[IBUF_IDX_W] || !i_valid_vec[w_cur]) begin
        w_stop = 1'b1;
      end else if (!i_uncompressed_vec[w_cur]) begin
        o_valid_by_way_c[k]   = 1'b1;
        o_deqing_vec_c[w_cur] = 1'b1;
        w_ptr                 = w_ptr + PTR_W'(1);
      end else if ((w_cur != LAST_IDX) && i_valid_vec[w_nxt]) begin
        o_valid_by_way_c[k]   = 1'b1;
        o_deqing_vec_c[w_cur] = 1'b1;
        o_deqing_vec_c[w_nxt] = 1'b1;
        w_ptr                 = w_ptr + PTR_W'(2);
      end else if ((w_cur == LAST_IDX) && i_redirect_vec[LAST_IDX]) begin
        o_valid_by_way_c[k]   = 1'b1;
        o_deqing_vec_c[w_cur] = 1'b1;
        w_ptr                 = w_ptr + PTR_W'(1);
      end else begin
        w_stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ibuffer_ctrl.sv
// Two-bank instruction buffer: accepts 16B fetch blocks into the lowest free bank,
// presents up to four instructions per cycle, and shifts bank1 down as bank0 drains.
module ibuffer_ctrl
  import ibuffer_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  ibuffer_ctrl_if.slave  if_ibuf
);

  localparam int unsigned BPC_W = PC_WIDTH - IBUF_BLK_OFS_W;
  localparam int unsigned BANK  = IBUF_BANK_SLOTS;
  localparam logic [IBUF_IDX_W-1:0] LAST_IDX = IBUF_IDX_W'(IBUF_SLOTS - 1);

  ibuf_slot_t [IBUF_SLOTS-1:0]            r_slot;
  ibuf_slot_t [IBUF_SLOTS-1:0]            w_next_slot;
  ibuf_slot_t [BANK-1:0]                  w_enq_bank;
  logic [1:0][BPC_W-1:0]                  r_bank_pc;
  logic [1:0][BPC_W-1:0]                  w_next_bank_pc;

  logic [IBUF_SLOTS-1:0]                  w_valid_vec;
  logic [IBUF_SLOTS-1:0]                  w_unc_vec;
  logic [IBUF_SLOTS-1:0]                  w_redir_vec;
  logic [IBUF_SLOTS-1:0]                  w_deqing_vec;
  logic [IBUF_SLOTS-1:0]                  w_post_valid;
  logic [IBUF_WAYS-1:0]                   w_valid_by_way;
  logic [IBUF_WAYS-1:0][IBUF_IDX_W-1:0]   w_first_idx;

  logic w_deq_fire;
  logic w_enq_ready;
  logic w_enq_fire;
  logic w_b0e;
  logic w_b1e;
  logic w_unused_pc_lo;

  // Block PCs are 16B aligned, so the low nibble carries no information.
  assign w_unused_pc_lo = ^if_ibuf.enq_pc[IBUF_BLK_OFS_W-1:0];

  always_comb begin
    w_valid_vec = '0;
    w_unc_vec   = '0;
    w_redir_vec = '0;
    for (int i = 0; i < IBUF_SLOTS; i++) begin
      w_valid_vec[i] = r_slot[i].valid;
      w_unc_vec[i]   = r_slot[i].uncompressed;
      w_redir_vec[i] = r_slot[i].redirect;
    end
  end

  ibuffer_deqer u_deqer (
    .i_valid_vec          (w_valid_vec),
    .i_uncompressed_vec   (w_unc_vec),
    .i_redirect_vec       (w_redir_vec),
    .o_valid_by_way_c     (w_valid_by_way),
    .o_first_idx_by_way_c (w_first_idx),
    .o_deqing_vec_c       (w_deqing_vec)
  );

  // Per-way payload/PC selection; the upper halfword past the last slot reads as zero.
  always_comb begin
    if_ibuf.deq_instr_by_way        = '0;
    if_ibuf.deq_pc_by_way           = '0;
    if_ibuf.deq_uncompressed_by_way = '0;
    if_ibuf.deq_redirect_by_way     = '0;
    for (int k = 0; k < IBUF_WAYS; k++) begin
      if_ibuf.deq_instr_by_way[k][IBUF_HW_W-1:0] = r_slot[w_first_idx[k]].hw;
      if (w_first_idx[k] != LAST_IDX) begin
        if_ibuf.deq_instr_by_way[k][IBUF_INSTR_W-1:IBUF_HW_W] =
          r_slot[w_first_idx[k] + IBUF_IDX_W'(1)].hw;
      end
      if_ibuf.deq_pc_by_way[k] = {r_bank_pc[w_first_idx[k][IBUF_IDX_W-1]],
                                  w_first_idx[k][IBUF_IDX_W-2:0], 1'b0};
      if_ibuf.deq_uncompressed_by_way[k] = r_slot[w_first_idx[k]].uncompressed;
      if_ibuf.deq_redirect_by_way[k]     = r_slot[w_first_idx[k]].redirect;
    end
  end

  assign if_ibuf.deq_valid_by_way = w_valid_by_way & {IBUF_WAYS{~if_ibuf.flush}};

  assign w_deq_fire  = if_ibuf.deq_ready & (|w_valid_by_way) & ~if_ibuf.flush;
  assign w_enq_ready = ~if_ibuf.flush &
                       (~|w_valid_vec[BANK-1:0] | ~|w_valid_vec[IBUF_SLOTS-1:BANK]);
  assign w_enq_fire  = if_ibuf.enq_valid & w_enq_ready;
  assign if_ibuf.enq_ready = w_enq_ready;

  assign w_post_valid = w_deq_fire ? (w_valid_vec & ~w_deqing_vec) : w_valid_vec;
  assign w_b0e        = ~|w_post_valid[BANK-1:0];
  assign w_b1e        = ~|w_post_valid[IBUF_SLOTS-1:BANK];

  always_comb begin
    w_enq_bank = '0;
    for (int i = 0; i < BANK; i++) begin
      w_enq_bank[i] = ibuf_mk_slot(if_ibuf.enq_valid_vec[i],
                                   if_ibuf.enq_uncompressed_vec[i],
                                   if_ibuf.enq_redirect_vec[i],
                                   if_ibuf.enq_halfword_by_slot[i]);
    end
  end

  // Retire dequeued slots, shift bank1 down when bank0 drains, then place the new block.
  always_comb begin
    w_next_slot    = r_slot;
    w_next_bank_pc = r_bank_pc;
    for (int i = 0; i < IBUF_SLOTS; i++) begin
      w_next_slot[i].valid = w_post_valid[i];
    end

    if (w_b0e && !w_b1e) begin
      w_next_slot[BANK-1:0] = w_next_slot[IBUF_SLOTS-1:BANK];
      w_next_bank_pc[0]     = r_bank_pc[1];
      for (int i = BANK; i < IBUF_SLOTS; i++) begin
        w_next_slot[i].valid = 1'b0;
      end
      if (w_enq_fire) begin
        w_next_slot[IBUF_SLOTS-1:BANK] = w_enq_bank;
        w_next_bank_pc[1]              = if_ibuf.enq_pc[PC_WIDTH-1:IBUF_BLK_OFS_W];
      end
    end else if (w_enq_fire) begin
      if (w_b0e) begin
        w_next_slot[BANK-1:0] = w_enq_bank;
        w_next_bank_pc[0]     = if_ibuf.enq_pc[PC_WIDTH-1:IBUF_BLK_OFS_W];
      end else begin
        w_next_slot[IBUF_SLOTS-1:BANK] = w_enq_bank;
        w_next_bank_pc[1]              = if_ibuf.enq_pc[PC_WIDTH-1:IBUF_BLK_OFS_W];
      end
    end

    if (if_ibuf.flush) begin
      for (int i = 0; i < IBUF_SLOTS; i++) begin
        w_next_slot[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slot    <= '0;
      r_bank_pc <= '0;
    end else begin
      r_slot    <= w_next_slot;
      r_bank_pc <= w_next_bank_pc;
    end
  end

endmodule
